// File: rtl/ray_pkg.sv
// Shared FSM type, component indices and fixed-point helpers for the ray path.
// Define PLANE_DIST_SAT_EN for saturating narrowing; otherwise results wrap.
package ray_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        WRITE
    } state_t;

    localparam int X = 0;
    localparam int Y = 1;
    localparam int Z = 2;

    localparam int MAX_W = 64;
    localparam int ACC_W = 2 * MAX_W + 3;

    // Component k of a packed vec3 of w-bit fields, sign-extended to MAX_W.
    function automatic logic [MAX_W-1:0] vec3_comp(
        input logic [3*MAX_W-1:0] v,
        input int                 w,
        input int                 k
    );
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++)
            r[i] = (i < w) ? v[k*w+i] : v[k*w+w-1];
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] fx_narrow(
        input logic signed [ACC_W-1:0] acc,
        input int                      q,
        input int                      w
    );
        logic signed [ACC_W-1:0] s;
`ifdef PLANE_DIST_SAT_EN
        logic signed [ACC_W-1:0] one;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
`endif
        s = acc >>> q;
`ifdef PLANE_DIST_SAT_EN
        one = {{(ACC_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
`endif
        return s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/fixed_mac.sv
// Single signed multiplier feeding a two-entry accumulator bank.
// sel picks the numerator (0) or denominator (1) accumulator.
module fixed_mac #(
    parameter int AW = 32,
    parameter int BW = 33,
    parameter int CW = 67
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 sel,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [CW-1:0] acc_num,
    output logic signed [CW-1:0] acc_den
);

    logic signed [AW+BW-1:0] prod;
    logic signed [CW-1:0]    prod_x;

    assign prod   = a * b;
    assign prod_x = CW'(prod);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_num <= '0;
            acc_den <= '0;
        end else if (clr) begin
            acc_num <= '0;
            acc_den <= '0;
        end else if (en) begin
            if (sel)
                acc_den <= acc_den + prod_x;
            else
                acc_num <= acc_num + prod_x;
        end
    end

endmodule

// File: rtl/plane_dist_operands.sv
// Ray/plane operand stage: dividend N.(P-O) and divisor N.D over six MAC cycles.
// PLANE_DIST_SAT_EN selects saturating output narrowing.
module plane_dist_operands
    import ray_pkg::*;
#(
    parameter int Q_BITS = 10,
    parameter int D_BITS = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3*D_BITS-1:0]      in_ray_orig,
    input  logic [3*D_BITS-1:0]      in_ray_dir,
    input  logic [3*D_BITS-1:0]      in_plane_pt,
    input  logic [3*D_BITS-1:0]      in_plane_nrm,
    input  logic                     in_empty,
    output logic                     in_rd_en,
    output logic signed [D_BITS-1:0] out_dividend,
    output logic signed [D_BITS-1:0] out_divisor,
    output logic                     out_wr_en,
    input  logic                     out_full
);

    localparam int CW = 2 * D_BITS + 3;

    state_t state, state_nx;
    logic [2:0] k;
    logic [1:0] idx;

    logic signed [D_BITS-1:0] n_r   [3];
    logic signed [D_BITS-1:0] d_r   [3];
    logic signed [D_BITS:0]   pmo_r [3];

    logic signed [D_BITS-1:0] n_in [3];
    logic signed [D_BITS-1:0] d_in [3];
    logic signed [D_BITS-1:0] p_in [3];
    logic signed [D_BITS-1:0] o_in [3];

    logic [3*MAX_W-1:0] ov, dv, pv, nv;

    logic                     mac_clr, mac_en, mac_sel;
    logic signed [D_BITS-1:0] mac_a;
    logic signed [D_BITS:0]   mac_b;
    logic signed [CW-1:0]     acc_num, acc_den;
    logic signed [ACC_W-1:0]  num_w, den_w;

    always_comb begin
        ov = '0;
        dv = '0;
        pv = '0;
        nv = '0;
        ov[3*D_BITS-1:0] = in_ray_orig;
        dv[3*D_BITS-1:0] = in_ray_dir;
        pv[3*D_BITS-1:0] = in_plane_pt;
        nv[3*D_BITS-1:0] = in_plane_nrm;
        for (int i = X; i <= Z; i++) begin
            o_in[i] = D_BITS'(vec3_comp(ov, D_BITS, i));
            d_in[i] = D_BITS'(vec3_comp(dv, D_BITS, i));
            p_in[i] = D_BITS'(vec3_comp(pv, D_BITS, i));
            n_in[i] = D_BITS'(vec3_comp(nv, D_BITS, i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nx;
            k     <= (state == MAC) ? k + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (!in_empty) state_nx = LOAD;
            LOAD:  state_nx = MAC;
            MAC:   if (k == 3'd5) state_nx = WRITE;
            WRITE: if (!out_full) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_rd_en  = (state == IDLE) && !in_empty && !reset;
        out_wr_en = (state == WRITE) && !out_full;
        mac_clr   = (state == LOAD);
        mac_en    = (state == MAC);
        mac_sel   = (k >= 3'd3);
    end

    // Differences carry one extra bit so P-O can never overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = X; i <= Z; i++) begin
                n_r[i]   <= '0;
                d_r[i]   <= '0;
                pmo_r[i] <= '0;
            end
        end else if (state == LOAD) begin
            for (int i = X; i <= Z; i++) begin
                n_r[i]   <= n_in[i];
                d_r[i]   <= d_in[i];
                pmo_r[i] <= {p_in[i][D_BITS-1], p_in[i]}
                          - {o_in[i][D_BITS-1], o_in[i]};
            end
        end
    end

    always_comb begin
        idx   = mac_sel ? 2'(k - 3'd3) : k[1:0];
        mac_a = n_r[idx];
        mac_b = mac_sel ? {d_r[idx][D_BITS-1], d_r[idx]} : pmo_r[idx];
    end

    fixed_mac #(
        .AW (D_BITS),
        .BW (D_BITS + 1),
        .CW (CW)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .clr     (mac_clr),
        .en      (mac_en),
        .sel     (mac_sel),
        .a       (mac_a),
        .b       (mac_b),
        .acc_num (acc_num),
        .acc_den (acc_den)
    );

    // Outputs derive only from the accumulator registers, so they hold in WRITE.
    always_comb begin
        num_w        = ACC_W'(acc_num);
        den_w        = ACC_W'(acc_den);
        out_dividend = D_BITS'(fx_narrow(num_w, Q_BITS, D_BITS));
        out_divisor  = D_BITS'(fx_narrow(den_w, Q_BITS, D_BITS));
    end

endmodule
